// File: rtl/seven_segment_display_decoder.sv
// Reads back a multiplexed 4-digit active-low 7-segment display: synchronizes the pins,
// filters transients, decodes each digit to BCD and publishes complete frames as BCD and binary.
module seven_segment_display_decoder #(
  parameter int STABLE_CYCLES = 1024
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic        value_valid,
  output logic        frame_valid,
  output logic        anode_err,
  output logic        seg_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  logic [10:0]   r_sync1;
  logic [10:0]   r_sync2;
  logic [10:0]   r_prev;
  logic [CW-1:0] r_stable_cnt;
  logic [15:0]   r_stage;
  logic [3:0]    r_mask;

  logic          w_same;
  logic          w_capture;
  logic [3:0]    w_anode;
  logic [6:0]    w_seg;
  logic          w_seg_ok;
  logic [3:0]    w_bcd;
  logic          w_dig_sel;
  logic [1:0]    w_idx;
  logic [15:0]   w_stage_next;
  logic [3:0]    w_mask_next;
  logic          w_anode_bad;
  logic          w_seg_bad;
  logic          w_frame_done;
  logic [13:0]   w_value_next;

  assign w_anode   = r_sync2[10:7];
  assign w_seg     = r_sync2[6:0];
  assign w_same    = (r_sync2 == r_prev);
  // Count saturates at STABLE_CYCLES, so the capture match happens once per steady interval.
  assign w_capture = w_same && (r_stable_cnt == CNT_CAP);

  always_comb begin
    w_seg_ok = 1'b1;
    w_bcd    = 4'd0;
    case (w_seg)
      7'b0000001: w_bcd = 4'd0;
      7'b1001111: w_bcd = 4'd1;
      7'b0010010: w_bcd = 4'd2;
      7'b0000110: w_bcd = 4'd3;
      7'b1001100: w_bcd = 4'd4;
      7'b0100100: w_bcd = 4'd5;
      7'b0100000: w_bcd = 4'd6;
      7'b0001111: w_bcd = 4'd7;
      7'b0000000: w_bcd = 4'd8;
      7'b0000100: w_bcd = 4'd9;
      default:    w_seg_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_dig_sel = 1'b1;
    w_idx     = 2'd0;
    case (w_anode)
      4'b0111: w_idx = 2'd3;
      4'b1011: w_idx = 2'd2;
      4'b1101: w_idx = 2'd1;
      4'b1110: w_idx = 2'd0;
      default: w_dig_sel = 1'b0;
    endcase
  end

  always_comb begin
    w_stage_next = r_stage;
    w_mask_next  = r_mask;
    w_anode_bad  = 1'b0;
    w_seg_bad    = 1'b0;
    if (w_capture) begin
      if (w_dig_sel) begin
        if (w_seg_ok) begin
          w_stage_next[{w_idx, 2'b00} +: 4] = w_bcd;
          w_mask_next[w_idx]                = 1'b1;
        end else begin
          w_mask_next[w_idx] = 1'b0;
          w_seg_bad          = 1'b1;
        end
      end else if (w_anode != 4'b1111) begin
        w_anode_bad = 1'b1;
      end
    end
  end

  assign w_frame_done = (w_mask_next == 4'b1111);
  assign w_value_next = {10'd0, w_stage_next[15:12]} * 14'd1000
                      + {10'd0, w_stage_next[11:8]}  * 14'd100
                      + {10'd0, w_stage_next[7:4]}   * 14'd10
                      + {10'd0, w_stage_next[3:0]};

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      r_sync1      <= '1;
      r_sync2      <= '1;
      r_prev       <= '1;
      r_stable_cnt <= '0;
      r_stage      <= '0;
      r_mask       <= '0;
      digits       <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      frame_valid  <= 1'b0;
      anode_err    <= 1'b0;
      seg_err      <= 1'b0;
    end else begin
      r_sync1 <= {anode_in, seg_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_same) begin
        r_stable_cnt <= '0;
      end else if (r_stable_cnt != CNT_SAT) begin
        r_stable_cnt <= r_stable_cnt + 1'b1;
      end
      r_stage     <= w_stage_next;
      r_mask      <= w_frame_done ? 4'b0000 : w_mask_next;
      frame_valid <= w_frame_done;
      anode_err   <= w_anode_bad;
      seg_err     <= w_seg_bad;
      if (w_frame_done) begin
        digits      <= w_stage_next;
        value       <= w_value_next;
        value_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seven_segment_display_decoder.md
# seven_segment_display_decoder

Receive-side counterpart of the multiplexed 4-digit 7-segment display controller. The block samples the active-low anode and cathode lines of a time-multiplexed display. It rejects transients with a stability filter and decodes each segment pattern back to BCD. It assembles complete 4-digit frames and outputs them as BCD and binary values. It is used for loopback self-test of the display path and for reading an external multiplexed display on the Basys 3.

## Interface
Parameters:
- STABLE_CYCLES, default 1024: consecutive identical synchronized samples required before a capture fires; must be ≥ 2.

Ports:
- clock_100Mhz  input  1  100 MHz system clock. All logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- anode_in  input  4  anode lines, active-low. Bit 3 low selects the thousands digit; bit 0 low selects the units digit.
- seg_in  input  7  cathode lines, active-low. Bit 6 is segment a and bit 0 is segment g ("0" = 7'b0000001).
- digits  output  16  last complete frame as BCD {thousands, hundreds, tens, units}.
- value  output  14  binary equivalent of `digits`, range 0–9999.
- value_valid  output  1  level signal; 1 once any frame has completed since reset.
- frame_valid  output  1  one-cycle pulse when `digits` and `value` update.
- anode_err  output  1  one-cycle pulse on a capture with an illegal anode pattern.
- seg_err  output  1  one-cycle pulse on a capture with a non-decimal segment pattern.

## Operation
- **Synchronizer:** anode_in and seg_in (11 bits) pass through a 2-flop synchronizer. Reset value of both stages is all-ones (display dark).
- **Stability filter:**
  - The synchronized 11-bit sample is compared with the previous sample. On any difference, stable_cnt resets to 0.
  - Otherwise stable_cnt increments, saturating at STABLE_CYCLES.
  - capture is strobed for exactly one cycle when a sample equals the previous sample and stable_cnt == STABLE_CYCLES−1. It fires at most once per stable interval.
- **Capture classification:**
  - anode 4'b1111: ignored silently, with no error.
  - anode 0111, 1011, 1101 or 1110: the selected digit is decoded.
  - Any other anode value: anode_err pulses, and the staging registers and mask are unchanged.
- **Segment decode:** only the ten patterns 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100 are valid; they decode to 0–9.
  - Valid pattern: the BCD value is written to that digit's staging register and its mask bit is set.
  - Invalid pattern: seg_err pulses and that digit's mask bit is cleared.
- **Repeat captures:** a repeated capture of an already-captured digit overwrites its staging value.
- **Frame completion:** when the next mask value is 4'b1111:
  - digits is loaded from staging (including the digit captured in the same cycle).
  - value = d3·1000 + d2·100 + d1·10 + d0 is loaded in the same cycle.
  - frame_valid pulses, value_valid is set to 1, and the mask clears to 0.
- **Reset:** every output is 0. Staging registers, mask and stable_cnt are 0.
- **Reset mid-frame:** a reset during a frame discards the partial mask; a full 4-digit set is required afterwards.

## Timing
- Latency from a pin change to the capture strobe is 2 (synchronizer) + STABLE_CYCLES cycles, assuming the pins hold steady.
- frame_valid, anode_err and seg_err are registered. They go high the cycle after the capture strobe and stay high for exactly 1 cycle.
- digits and value change only in the frame_valid cycle. They hold between frames.
- A pin glitch shorter than STABLE_CYCLES + 1 cycles never produces a capture. It also restarts the stability count for the following steady value.
- anode_err and seg_err are mutually exclusive, since only one capture occurs per cycle.
- frame_valid may coincide with neither error.
- value arithmetic is performed with unsigned width ≥ 14 bits, with no overflow (max 9999).

## Test plan
All scenarios use STABLE_CYCLES = 4.
- **Normal frame:** drive anode 0111/1011/1101/1110 with segment patterns for 1, 2, 3, 4, each held 16 cycles → single frame_valid pulse, digits = 16'h1234, value = 1234, value_valid = 1.
- **Glitch rejection:** during the "2" dwell, force seg_in = 0000000 for 3 cycles, then restore → no capture of 8, no errors, frame still reports 1234.
- **Invalid segment pattern:** digit 3 driven with seg_in = 1111111 for 16 cycles → one seg_err pulse, no frame_valid. Then drive a valid 4 → frame_valid, value = 1234.
- **Illegal anode:** hold anode 0011 for 16 cycles mid-frame → one anode_err pulse, mask unchanged. Completing the remaining digits yields the expected value.
- **Reset mid-frame:** assert reset after digits 1 and 2 are captured → all outputs 0 immediately. Then digits 3 and 4 alone do not produce frame_valid; a full 5678 sequence gives value = 5678.
- **Boundaries:** frames 9999 and 0000 → value 9999 then 0, with digits 16'h9999 then 16'h0000.
